// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity modes, rx FSM states, error flag bits, frame length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int ERR_FRAME = 0;
  localparam int ERR_PAR   = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    PUSH
  } rx_state_e;

  // Bits per character: start + data + optional parity + stop.
  function automatic int char_len(input int d_w,
                                  input int par,
                                  input int stop_b);
    return 1 + d_w + ((par != PAR_NONE) ? 1 : 0) + stop_b;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO with registered read data loaded on pop.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_ctrl_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en && (cnt_q != '0);
    do_wr    = wr_en && ((cnt_q != FULL_CNT) || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = dout_q;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign count   = cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver feeding a FIFO with per-word error flags.
// Optional idle timeout pulse: define UART_RX_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int D_W      = 8,
  parameter int B_TICK   = 16,
  parameter int DEPTH    = 64,
  parameter int PAR_MODE = 0,
  parameter int STOP_B   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   b_clk,
  input  logic                   rx_data,
  output logic                   b_en,
  input  logic                   rd_en,
  output logic [D_W-1:0]         ff_data_out,
  output logic [1:0]             ff_err_out,
  output logic                   ff_empty,
  output logic                   ff_full,
  output logic [$clog2(DEPTH):0] ff_count,
`ifdef UART_RX_TIMEOUT_EN
  output logic                   rx_timeout,
`endif
  output logic                   overrun
);

  localparam int TW = $clog2(B_TICK);
  localparam int BW = $clog2(D_W);
  localparam logic [TW-1:0] T_HALF = TW'(B_TICK/2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(B_TICK - 1);
  localparam logic [BW-1:0] D_LAST = BW'(D_W - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_B - 1);
  localparam logic ODD_PAR = (PAR_MODE == PAR_ODD);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [D_W-1:0]  shift_q, shift_d;
  logic [1:0]      err_q, err_d;
  logic            ovr_q, ovr_d;
  logic            line, fell, push, drop;
  logic [D_W+1:0]  ff_rd;

  assign line = sync2_q;
  assign fell = prev_q & ~sync2_q;
  assign b_en = ~rst;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (fell) begin
        state_d = START;
        tick_d  = '0;
        bit_d   = '0;
        err_d   = '0;
      end
      START: if (b_clk) begin
        if (tick_q == T_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = line ? IDLE : DATA;
        end else tick_d = tick_q + 1'b1;
      end
      DATA: if (b_clk) begin
        if (tick_q == T_LAST) begin
          tick_d  = '0;
          shift_d = {line, shift_q[D_W-1:1]};
          if (bit_q == D_LAST) begin
            bit_d   = '0;
            state_d = (PAR_MODE != PAR_NONE) ? PARITY : STOP;
          end else bit_d = bit_q + 1'b1;
        end else tick_d = tick_q + 1'b1;
      end
      PARITY: if (b_clk) begin
        if (tick_q == T_LAST) begin
          tick_d           = '0;
          err_d[ERR_PAR]   = ((^shift_q) ^ line) != ODD_PAR;
          state_d          = STOP;
        end else tick_d = tick_q + 1'b1;
      end
      STOP: if (b_clk) begin
        if (tick_q == T_LAST) begin
          tick_d = '0;
          if (!line) err_d[ERR_FRAME] = 1'b1;
          if (bit_q == S_LAST) state_d = PUSH;
          else bit_d = bit_q + 1'b1;
        end else tick_d = tick_q + 1'b1;
      end
      PUSH: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still takes the frame if the host pops in the same cycle.
  always_comb begin
    drop  = push && ff_full && !rd_en;
    ovr_d = ovr_q | drop;
`ifdef OVR_CLR_EN
    if (rd_en) ovr_d = drop;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      err_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx_data;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_rx_ctrl_fifo #(
    .W     (D_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({err_q, shift_q}),
    .rd_en   (rd_en),
    .rd_data (ff_rd),
    .empty   (ff_empty),
    .full    (ff_full),
    .count   (ff_count)
  );

  assign ff_data_out = ff_rd[D_W-1:0];
  assign ff_err_out  = ff_rd[D_W+1:D_W];
  assign overrun     = ovr_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIM = 4 * char_len(D_W, PAR_MODE, STOP_B) * B_TICK;
  localparam int IW = $clog2(TO_LIM + 1);
  localparam logic [IW-1:0] TO_MAX = IW'(TO_LIM);

  logic [IW-1:0] idle_q, idle_d;
  logic          to_q, to_d;

  // Counter saturates so the pulse fires once per idle stretch.
  always_comb begin
    idle_d = idle_q;
    to_d   = 1'b0;
    if ((state_q != IDLE) || fell || rd_en) idle_d = '0;
    else if (b_clk && (idle_q != TO_MAX)) begin
      idle_d = idle_q + 1'b1;
      to_d   = (idle_d == TO_MAX) && !ff_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign rx_timeout = to_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: 8N1/64-deep and 8E2/4-deep instances.
// Random tick pattern, random data, queue-based reference model.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int BT = 16;
  localparam logic [20:0] RST_STAT = {1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 10'd0};
  localparam logic [20:0] RUN_STAT = {1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 10'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_clk = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic rd_a = 1'b0, rd_b = 1'b0;
  logic b_en_a, b_en_b;
  logic [7:0] dout_a, dout_b;
  logic [1:0] err_a, err_b;
  logic emp_a, emp_b, full_a, full_b, ovr_a, ovr_b;
  logic [6:0] cnt_a;
  logic [2:0] cnt_b;
`ifdef UART_RX_TIMEOUT_EN
  logic to_a, to_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic ovr_exp[2];

  always #5 clk = ~clk;
  always @(negedge clk) b_clk = ($urandom_range(2) != 0);

  uart_rx_ctrl u_a (
    .clk(clk), .rst(rst), .b_clk(b_clk), .rx_data(rx_a),
    .b_en(b_en_a), .rd_en(rd_a), .ff_data_out(dout_a),
    .ff_err_out(err_a), .ff_empty(emp_a), .ff_full(full_a),
    .ff_count(cnt_a),
`ifdef UART_RX_TIMEOUT_EN
    .rx_timeout(to_a),
`endif
    .overrun(ovr_a)
  );

  uart_rx_ctrl #(
    .PAR_MODE(1), .STOP_B(2), .DEPTH(4)
  ) u_b (
    .clk(clk), .rst(rst), .b_clk(b_clk), .rx_data(rx_b),
    .b_en(b_en_b), .rd_en(rd_b), .ff_data_out(dout_b),
    .ff_err_out(err_b), .ff_empty(emp_b), .ff_full(full_b),
    .ff_count(cnt_b),
`ifdef UART_RX_TIMEOUT_EN
    .rx_timeout(to_b),
`endif
    .overrun(ovr_b)
  );

  function automatic logic [20:0] stat(int u);
    if (u == 0)
      return {b_en_a, emp_a, full_a, ovr_a, cnt_a, err_a, dout_a};
    return {b_en_b, emp_b, full_b, ovr_b, 4'b0, cnt_b, err_b, dout_b};
  endfunction

  function automatic logic [9:0] head(int u);
    return (u == 0) ? {err_a, dout_a} : {err_b, dout_b};
  endfunction

  // Expected word from the frame as sent on the wire.
  function automatic logic [9:0] model_word(int u, logic [7:0] d,
                                            logic pb, logic [1:0] st);
    logic fe, pe;
    fe = (u == 0) ? ~st[0] : ~(st[0] & st[1]);
    pe = (u == 1) && ((($countones(d) + int'(pb)) % 2) == 1);
    return {pe, fe, d};
  endfunction

  task automatic model_push(int u, logic [9:0] w);
    if (u == 0) begin
      if (qa.size() < 64) qa.push_back(w);
      else ovr_exp[0] = 1'b1;
    end else begin
      if (qb.size() < 4) qb.push_back(w);
      else ovr_exp[1] = 1'b1;
    end
  endtask

  task automatic tick_wait(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (b_clk !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic set_rx(int u, logic v);
    if (u == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send(int u, logic [7:0] d, logic pb,
                      logic [1:0] st, int gap);
    set_rx(u, 1'b0);
    tick_wait(BT);
    for (int i = 0; i < 8; i++) begin
      set_rx(u, d[i]);
      tick_wait(BT);
    end
    if (u == 1) begin
      set_rx(u, pb);
      tick_wait(BT);
    end
    set_rx(u, st[0]);
    tick_wait(BT);
    if (u == 1) begin
      set_rx(u, st[1]);
      tick_wait(BT);
    end
    set_rx(u, 1'b1);
    tick_wait(gap);
  endtask

  task automatic pop(int u);
    if (u == 0) rd_a = 1'b1;
    else rd_b = 1'b1;
    @(posedge clk);
    #1;
    rd_a = 1'b0;
    rd_b = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if (stat(u) !== RST_STAT) begin
        n_bad++;
        $display("FAIL reset_state u%0d: got %h want %h",
                 u, stat(u), RST_STAT);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if (stat(u) !== RUN_STAT) begin
        n_bad++;
        $display("FAIL after_reset u%0d: got %h want %h",
                 u, stat(u), RUN_STAT);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] d;
    logic [9:0] e;
    send(0, 8'hA5, 1'b0, 2'b11, 2);
    model_push(0, model_word(0, 8'hA5, 1'b0, 2'b11));
    n_cmp++;
    if ({emp_a, cnt_a} !== {1'b0, 7'd1}) begin
      n_bad++;
      $display("FAIL a5_level: got %b/%0d want 0/1", emp_a, cnt_a);
    end
    pop(0);
    e = qa.pop_front();
    n_cmp++;
    if (head(0) !== 10'h0A5 || e !== 10'h0A5) begin
      n_bad++;
      $display("FAIL a5_pop: got %h want %h", head(0), 10'h0A5);
    end
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      send(0, d, 1'b0, 2'b11, $urandom_range(3));
      model_push(0, model_word(0, d, 1'b0, 2'b11));
    end
    n_cmp++;
    if (int'(cnt_a) != qa.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d want %0d", cnt_a, qa.size());
    end
    while (qa.size() > 0) begin
      pop(0);
      e = qa.pop_front();
      n_cmp++;
      if (head(0) !== e) begin
        n_bad++;
        $display("FAIL rand_pop: got %h want %h", head(0), e);
      end
    end
    n_cmp++;
    if (emp_a !== 1'b1) begin
      n_bad++;
      $display("FAIL rand_empty: got %b want 1", emp_a);
    end
  endtask

  task automatic test_parity;
    logic [7:0] d;
    logic pb;
    logic [9:0] e;
    send(1, 8'h03, 1'b1, 2'b11, 2);
    pop(1);
    n_cmp++;
    if (head(1) !== 10'h203) begin
      n_bad++;
      $display("FAIL par_bad: got %h want %h", head(1), 10'h203);
    end
    send(1, 8'h03, 1'b0, 2'b11, 2);
    pop(1);
    n_cmp++;
    if (head(1) !== 10'h003) begin
      n_bad++;
      $display("FAIL par_good: got %h want %h", head(1), 10'h003);
    end
    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      pb = 1'($urandom);
      send(1, d, pb, 2'b11, $urandom_range(3));
      e = model_word(1, d, pb, 2'b11);
      pop(1);
      n_cmp++;
      if (head(1) !== e) begin
        n_bad++;
        $display("FAIL par_rand: got %h want %h", head(1), e);
      end
    end
  endtask

  task automatic test_frame_err;
    send(0, 8'h5A, 1'b0, 2'b10, 3);
    pop(0);
    n_cmp++;
    if (head(0) !== 10'h15A) begin
      n_bad++;
      $display("FAIL frame_a: got %h want %h", head(0), 10'h15A);
    end
    send(1, 8'h5A, 1'b0, 2'b01, 3);
    pop(1);
    n_cmp++;
    if (head(1) !== 10'h15A) begin
      n_bad++;
      $display("FAIL frame_b2: got %h want %h", head(1), 10'h15A);
    end
    send(1, 8'h5A, 1'b0, 2'b10, 3);
    pop(1);
    n_cmp++;
    if (head(1) !== 10'h15A) begin
      n_bad++;
      $display("FAIL frame_b1: got %h want %h", head(1), 10'h15A);
    end
  endtask

  task automatic test_glitch;
    set_rx(0, 1'b0);
    tick_wait(4);
    set_rx(0, 1'b1);
    tick_wait(3 * BT);
    n_cmp++;
    if ({emp_a, cnt_a} !== {1'b1, 7'd0} || u_a.state_q != IDLE) begin
      n_bad++;
      $display("FAIL glitch: got %b/%0d/%0d want 1/0/%0d",
               emp_a, cnt_a, u_a.state_q, IDLE);
    end
    send(0, 8'h3C, 1'b0, 2'b11, 2);
    pop(0);
    n_cmp++;
    if (head(0) !== 10'h03C) begin
      n_bad++;
      $display("FAIL post_glitch: got %h want %h", head(0), 10'h03C);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    logic [9:0] e;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      send(1, d, ^d, 2'b11, 2);
      model_push(1, model_word(1, d, ^d, 2'b11));
    end
    n_cmp++;
    if ({full_b, cnt_b, ovr_b} !== {1'b1, 3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL fill: got %b/%0d/%b want 1/4/0",
               full_b, cnt_b, ovr_b);
    end
    send(1, 8'hFF, 1'b0, 2'b11, 2);
    model_push(1, model_word(1, 8'hFF, 1'b0, 2'b11));
    n_cmp++;
    if ({full_b, cnt_b, ovr_b} !== {1'b1, 3'd4, ovr_exp[1]}) begin
      n_bad++;
      $display("FAIL overrun: got %b/%0d/%b want 1/4/%b",
               full_b, cnt_b, ovr_b, ovr_exp[1]);
    end
    pop(1);
    e = qb.pop_front();
    n_cmp++;
    if (head(1) !== e || cnt_b !== 3'd3) begin
      n_bad++;
      $display("FAIL ovr_head: got %h/%0d want %h/3", head(1), cnt_b, e);
    end
  endtask

  task automatic test_pop_at_push;
    logic [7:0] d;
    logic [9:0] e;
    logic hit;
    d = 8'($urandom);
    send(1, d, ^d, 2'b11, 2);
    model_push(1, model_word(1, d, ^d, 2'b11));
    d = 8'h6B;
    hit = 1'b0;
    fork
      send(1, d, ^d, 2'b11, 2);
      begin
        int n = 0;
        while (u_b.state_q != PUSH && n < 5000) begin
          @(posedge clk);
          #1;
          n++;
        end
        if (u_b.state_q == PUSH) begin
          hit = 1'b1;
          rd_b = 1'b1;
          @(posedge clk);
          #1;
          rd_b = 1'b0;
        end
      end
    join
    n_cmp++;
    if (hit !== 1'b1) begin
      n_bad++;
      $display("FAIL push_wait: got %b want 1 (no PUSH seen)", hit);
    end
    e = qb.pop_front();
    qb.push_back(model_word(1, d, ^d, 2'b11));
    n_cmp++;
    if (head(1) !== e || {full_b, cnt_b} !== {1'b1, 3'd4}) begin
      n_bad++;
      $display("FAIL pop_push: got %h/%b/%0d want %h/1/4",
               head(1), full_b, cnt_b, e);
    end
    while (qb.size() > 0) begin
      pop(1);
      e = qb.pop_front();
      n_cmp++;
      if (head(1) !== e) begin
        n_bad++;
        $display("FAIL drain_b: got %h want %h", head(1), e);
      end
    end
  endtask

  task automatic test_reset_mid;
    send(0, 8'h11, 1'b0, 2'b11, 2);
    model_push(0, model_word(0, 8'h11, 1'b0, 2'b11));
    set_rx(0, 1'b0);
    tick_wait(BT);
    for (int i = 0; i < 3; i++) begin
      set_rx(0, 1'($urandom));
      tick_wait(BT);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      n_cmp++;
      if (stat(u) !== RST_STAT) begin
        n_bad++;
        $display("FAIL mid_reset u%0d: got %h want %h",
                 u, stat(u), RST_STAT);
      end
    end
    rst = 1'b0;
    set_rx(0, 1'b1);
    qa.delete();
    qb.delete();
    ovr_exp[0] = 1'b0;
    ovr_exp[1] = 1'b0;
    tick_wait(12 * BT);
    n_cmp++;
    if (stat(0) !== RUN_STAT) begin
      n_bad++;
      $display("FAIL no_push: got %h want %h", stat(0), RUN_STAT);
    end
    send(0, 8'h81, 1'b0, 2'b11, 2);
    pop(0);
    n_cmp++;
    if (head(0) !== 10'h081) begin
      n_bad++;
      $display("FAIL post_reset: got %h want %h", head(0), 10'h081);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ovr_exp[0] = 1'b0;
    ovr_exp[1] = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_pop_at_push();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
